// File: rtl/link_vc_credit_arbiter_if.sv
// Link-side bundle for the VC credit arbiter: per-channel flit inputs, the shared
// link output and the credit return path.
interface link_vc_credit_arbiter_if #(
   parameter int unsigned N_IN       = 4,
   parameter int unsigned LINK_WIDTH = 16,
   parameter int unsigned VC_W       = $clog2(N_IN)
);
   logic [N_IN*LINK_WIDTH-1:0] data_in;
   logic [N_IN-1:0]            valid_in;
   logic [N_IN-1:0]            last_in;
   logic [N_IN-1:0]            ready_out;
   logic [LINK_WIDTH-1:0]      data_out;
   logic                       valid_out;
   logic [VC_W-1:0]            vc_out;
   logic                       last_out;
   logic                       cr_upd_valid;
   logic [VC_W-1:0]            cr_upd_vc;
   logic                       cr_err;

   // Driver of the channel flits and of the receiver credit returns.
   modport master (
      output data_in, valid_in, last_in, cr_upd_valid, cr_upd_vc,
      input  ready_out, data_out, valid_out, vc_out, last_out, cr_err
   );

   // The arbiter itself.
   modport slave (
      input  data_in, valid_in, last_in, cr_upd_valid, cr_upd_vc,
      output ready_out, data_out, valid_out, vc_out, last_out, cr_err
   );
endinterface

// File: rtl/link_vc_credit_arbiter.sv
// Shares one credit-based link among N_IN virtual channels: per-VC credit counters,
// packet-atomic round-robin selection and an optionally registered link output.
module link_vc_credit_arbiter #(
   parameter int unsigned N_IN        = 4,
   parameter int unsigned LINK_WIDTH  = 16,
   parameter int unsigned MAX_CREDITS = 3,
   parameter bit          REG_OUT     = 1'b1,
   parameter int unsigned VC_W        = $clog2(N_IN)
) (
   input logic                     clk,
   input logic                     rst,
   link_vc_credit_arbiter_if.slave link
);
   localparam int unsigned CW = $clog2(MAX_CREDITS + 1);
   localparam logic [CW-1:0] CrMax = CW'(MAX_CREDITS);

   logic [CW-1:0]   credits_q [N_IN];
   logic [CW-1:0]   credits_d [N_IN];
   logic [VC_W-1:0] rr_ptr_q;
   logic [VC_W-1:0] lock_vc_q;
   logic            lock_q;
   logic            cr_err_q, cr_err_d;

   logic [N_IN-1:0] elig;
   logic [N_IN-1:0] consume;
   logic [N_IN-1:0] credit_ret;
   logic            grant_valid;
   logic [VC_W-1:0] grant_vc;
   logic [VC_W-1:0] scan_idx;
   logic [VC_W-1:0] next_ptr;
   logic            xfer;
   logic [LINK_WIDTH-1:0] flit_data;
   logic            flit_last;

   // Credits returned this cycle are deliberately not visible until the next one.
   always_comb begin
      for (int unsigned i = 0; i < N_IN; i++) begin
         elig[i] = link.valid_in[i] & (credits_q[i] != '0);
      end
   end

   always_comb begin
      grant_valid = 1'b0;
      grant_vc    = '0;
      scan_idx    = '0;
      if (lock_q) begin
         if (elig[lock_vc_q]) begin
            grant_valid = 1'b1;
            grant_vc    = lock_vc_q;
         end
      end else begin
         for (int unsigned k = 0; k < N_IN; k++) begin
            scan_idx = VC_W'((32'(rr_ptr_q) + k) % N_IN);
            if (!grant_valid && elig[scan_idx]) begin
               grant_valid = 1'b1;
               grant_vc    = scan_idx;
            end
         end
      end
   end

   assign xfer      = grant_valid;
   assign flit_data = link.data_in[32'(grant_vc)*LINK_WIDTH +: LINK_WIDTH];
   assign flit_last = link.last_in[grant_vc];
   assign next_ptr  = (32'(grant_vc) == N_IN - 1) ? '0 : grant_vc + 1'b1;

   always_comb begin
      link.ready_out = '0;
      if (grant_valid) link.ready_out[grant_vc] = 1'b1;
   end

   always_comb begin
      for (int unsigned i = 0; i < N_IN; i++) begin
         consume[i]    = xfer && (grant_vc == VC_W'(i));
         credit_ret[i] = link.cr_upd_valid && (link.cr_upd_vc == VC_W'(i));
      end
   end

   // A consume and a return on the same VC cancel out, so the full-counter check
   // only applies to a bare return.
   always_comb begin
      cr_err_d = cr_err_q;
      if (link.cr_upd_valid && (32'(link.cr_upd_vc) >= N_IN)) cr_err_d = 1'b1;
      for (int unsigned i = 0; i < N_IN; i++) begin
         credits_d[i] = credits_q[i];
         if (consume[i] && !credit_ret[i]) begin
            credits_d[i] = credits_q[i] - 1'b1;
         end else if (credit_ret[i] && !consume[i]) begin
            if (credits_q[i] == CrMax) cr_err_d = 1'b1;
            else credits_d[i] = credits_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < N_IN; i++) credits_q[i] <= CrMax;
         cr_err_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N_IN; i++) credits_q[i] <= credits_d[i];
         cr_err_q <= cr_err_d;
      end
   end

   // The pointer only advances on packet completion so a packet never interleaves.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q  <= '0;
         lock_q    <= 1'b0;
         lock_vc_q <= '0;
      end else if (xfer) begin
         if (flit_last) begin
            lock_q   <= 1'b0;
            rr_ptr_q <= next_ptr;
         end else begin
            lock_q    <= 1'b1;
            lock_vc_q <= grant_vc;
         end
      end
   end

   assign link.cr_err = cr_err_q;

   if (REG_OUT) begin : g_reg_out
      logic [LINK_WIDTH-1:0] data_q;
      logic                  valid_q;
      logic [VC_W-1:0]       vc_q;
      logic                  last_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            vc_q    <= '0;
            last_q  <= 1'b0;
         end else begin
            valid_q <= xfer;
            if (xfer) begin
               data_q <= flit_data;
               vc_q   <= grant_vc;
               last_q <= flit_last;
            end
         end
      end

      assign link.data_out  = data_q;
      assign link.valid_out = valid_q;
      assign link.vc_out    = vc_q;
      assign link.last_out  = last_q;
   end else begin : g_comb_out
      assign link.data_out  = flit_data;
      assign link.valid_out = xfer;
      assign link.vc_out    = grant_vc;
      assign link.last_out  = flit_last;
   end
endmodule

// File: tb/tb_link_vc_credit_arbiter.sv
// Directed scoreboard bench for link_vc_credit_arbiter: registered-output instance for
// arbitration/credit behaviour, combinational-output instance for same-cycle forwarding.
module tb_link_vc_credit_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   link_vc_credit_arbiter_if #(.N_IN(4), .LINK_WIDTH(16), .VC_W(2)) r_if ();
   link_vc_credit_arbiter_if #(.N_IN(4), .LINK_WIDTH(16), .VC_W(2)) c_if ();

   link_vc_credit_arbiter #(
      .N_IN(4), .LINK_WIDTH(16), .MAX_CREDITS(3), .REG_OUT(1'b1), .VC_W(2)
   ) dut_r (
      .clk  (clk),
      .rst  (rst),
      .link (r_if)
   );

   link_vc_credit_arbiter #(
      .N_IN(4), .LINK_WIDTH(16), .MAX_CREDITS(3), .REG_OUT(1'b0), .VC_W(2)
   ) dut_c (
      .clk  (clk),
      .rst  (rst),
      .link (c_if)
   );

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  vc;
      logic        last;
   } flit_t;

   flit_t exp_q[$];
   flit_t mon_f;
   int    n_pass  = 0;
   int    n_total = 0;
   int    cyc     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   function automatic logic [15:0] flit_data(input int ch);
      return 16'((ch << 12) | (cyc & 12'hFFF));
   endfunction

   // One clock of stimulus on the registered instance; expected link flits are queued
   // for every channel the bench expects to be granted.
   task automatic cycle(input string name, input logic [3:0] v, input logic [3:0] l,
                        input logic cv, input logic [1:0] cvc, input logic [3:0] exp_ready);
      @(posedge clk);
      #1;
      cyc++;
      r_if.valid_in     = v;
      r_if.last_in      = l;
      r_if.cr_upd_valid = cv;
      r_if.cr_upd_vc    = cvc;
      for (int i = 0; i < 4; i++) r_if.data_in[i*16 +: 16] = flit_data(i);
      for (int i = 0; i < 4; i++) begin
         if (exp_ready[i]) exp_q.push_back('{data: flit_data(i), vc: 2'(i), last: l[i]});
      end
      @(negedge clk);
      check(name, 32'(r_if.ready_out), 32'(exp_ready));
   endtask

   // Link monitor for the registered instance.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && r_if.valid_out) begin
            if (exp_q.size() == 0) begin
               check("link_unexpected_flit", 32'(r_if.vc_out), 32'hFFFF_FFFF);
            end else begin
               mon_f = exp_q.pop_front();
               check("link_data", 32'(r_if.data_out), 32'(mon_f.data));
               check("link_vc", 32'(r_if.vc_out), 32'(mon_f.vc));
               check("link_last", 32'(r_if.last_out), 32'(mon_f.last));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

   initial begin
      r_if.data_in = '0; r_if.valid_in = '0; r_if.last_in = '0;
      r_if.cr_upd_valid = 1'b0; r_if.cr_upd_vc = '0;
      c_if.data_in = '0; c_if.valid_in = '0; c_if.last_in = '0;
      c_if.cr_upd_valid = 1'b0; c_if.cr_upd_vc = '0;

      // Reset state
      #12;
      check("rst_valid_out", 32'(r_if.valid_out), 32'd0);
      check("rst_data_out", 32'(r_if.data_out), 32'd0);
      check("rst_vc_out", 32'(r_if.vc_out), 32'd0);
      check("rst_last_out", 32'(r_if.last_out), 32'd0);
      check("rst_cr_err", 32'(r_if.cr_err), 32'd0);
      check("rst_ready", 32'(r_if.ready_out), 32'd0);
      check("rst_comb_valid", 32'(c_if.valid_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // All channels stream single-flit packets; credits come back 2 cycles after the link flit
      for (int k = 0; k < 15; k++) begin
         cycle("rr_ready", (k < 12) ? 4'hF : 4'h0, 4'hF, k >= 3,
               (k >= 3) ? 2'((k - 3) % 4) : 2'd0, (k < 12) ? 4'(1 << (k % 4)) : 4'h0);
         if (k >= 1 && k <= 12) check("rr_valid_out", 32'(r_if.valid_out), 32'd1);
      end
      check("rr_cr_err", 32'(r_if.cr_err), 32'd0);

      // Move rr_ptr to 1, then a 4-flit packet on ch1 competing with ch0 and ch2
      cycle("pkt_ch0_single", 4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001);
      for (int k = 0; k < 3; k++) cycle("pkt_ch1_body", 4'b0111, 4'b0101, 1'b0, 2'd0, 4'b0010);
      cycle("pkt_locked_no_credit", 4'b0111, 4'b0101, 1'b0, 2'd0, 4'b0000);
      cycle("pkt_return_not_bypassed", 4'b0111, 4'b0101, 1'b1, 2'd1, 4'b0000);
      cycle("pkt_ch1_last", 4'b0111, 4'b0111, 1'b0, 2'd0, 4'b0010);
      cycle("pkt_then_ch2", 4'b0101, 4'b0101, 1'b0, 2'd0, 4'b0100);
      cycle("pkt_restore0", 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0000);
      for (int k = 0; k < 3; k++) cycle("pkt_restore1", 4'b0000, 4'b0000, 1'b1, 2'd1, 4'b0000);
      cycle("pkt_restore2", 4'b0000, 4'b0000, 1'b1, 2'd2, 4'b0000);
      check("pkt_cr_err", 32'(r_if.cr_err), 32'd0);

      // Channel 0 alone exhausts its 3 credits; one return admits exactly one more flit
      for (int k = 0; k < 3; k++) cycle("ch0_credit_flit", 4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001);
      cycle("ch0_starved_a", 4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0000);
      cycle("ch0_starved_b", 4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0000);
      cycle("ch0_return_cycle", 4'b0001, 4'b0001, 1'b1, 2'd0, 4'b0000);
      cycle("ch0_after_return", 4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001);
      cycle("ch0_starved_c", 4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0000);
      for (int k = 0; k < 3; k++) cycle("ch0_restore", 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0000);

      // Same-cycle consume and return on ch3, then an overflowing return on ch0
      cycle("ch3_first", 4'b1000, 4'b1000, 1'b0, 2'd0, 4'b1000);
      cycle("ch3_send_and_return", 4'b1000, 4'b1000, 1'b1, 2'd3, 4'b1000);
      cycle("ovf_return_ch0", 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0000);
      check("ch3_credits_unchanged", 32'(dut_r.credits_q[3]), 32'd2);
      check("ch3_no_err", 32'(r_if.cr_err), 32'd0);
      cycle("ovf_idle", 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000);
      check("ovf_cr_err", 32'(r_if.cr_err), 32'd1);
      check("ovf_credits_sat", 32'(dut_r.credits_q[0]), 32'd3);
      cycle("ch3_restore", 4'b0000, 4'b0000, 1'b1, 2'd3, 4'b0000);
      check("ovf_cr_err_sticky", 32'(r_if.cr_err), 32'd1);

      // Reset asserted mid-packet while locked on ch2 with one credit left
      cycle("rst_pkt_a", 4'b0100, 4'b0000, 1'b0, 2'd0, 4'b0100);
      cycle("rst_pkt_b", 4'b0100, 4'b0000, 1'b0, 2'd0, 4'b0100);
      @(posedge clk);
      #2;
      check("pre_rst_lock", 32'(dut_r.lock_q), 32'd1);
      check("pre_rst_credits2", 32'(dut_r.credits_q[2]), 32'd1);
      check("pre_rst_valid_out", 32'(r_if.valid_out), 32'd1);
      rst = 1'b0;
      r_if.valid_in = '0;
      #1;
      // The second flit was in the output register and is dropped by the reset.
      void'(exp_q.pop_back());
      check("async_rst_valid_out", 32'(r_if.valid_out), 32'd0);
      for (int i = 0; i < 4; i++) check("async_rst_credits", 32'(dut_r.credits_q[i]), 32'd3);
      check("async_rst_lock", 32'(dut_r.lock_q), 32'd0);
      check("async_rst_cr_err", 32'(r_if.cr_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      cycle("post_rst_vc0_first", 4'b1111, 4'b1111, 1'b0, 2'd0, 4'b0001);
      cycle("post_rst_restore", 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0000);

      // Combinational-output instance forwards in the grant cycle
      @(posedge clk);
      #1;
      c_if.valid_in = 4'b0100;
      c_if.last_in  = 4'b0100;
      c_if.data_in[2*16 +: 16] = 16'hA5A5;
      @(negedge clk);
      check("comb_ready", 32'(c_if.ready_out), 32'h4);
      check("comb_valid_out", 32'(c_if.valid_out), 32'd1);
      check("comb_data_out", 32'(c_if.data_out), 32'hA5A5);
      check("comb_vc_out", 32'(c_if.vc_out), 32'd2);
      check("comb_last_out", 32'(c_if.last_out), 32'd1);
      @(posedge clk);
      #1;
      c_if.valid_in = '0;
      @(negedge clk);
      check("comb_idle_valid", 32'(c_if.valid_out), 32'd0);
      check("comb_idle_ready", 32'(c_if.ready_out), 32'd0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/link_vc_credit_arbiter.md
Name: link_vc_credit_arbiter

Overview:
Shares one credit-based NoC link among N_IN input channels (virtual channels), each with its own receiver-side buffer of MAX_CREDITS slots.
- Keeps one credit counter per channel.
- Picks one eligible flit per cycle by packet-atomic round-robin.
- Drives the shared link with a channel id, optionally through a pipeline register.
- Sits in front of a router output port, in place of one sender flow controller per VC.

Parameters:
N_IN, 4, number of input channels / VCs (>=2)
LINK_WIDTH, 16, flit width in bits
MAX_CREDITS, 3, receiver slots per channel; credit counters are $clog2(MAX_CREDITS+1) bits wide
REG_OUT, 1, 1 = registered link outputs (+1 cycle latency); 0 = combinational outputs
VC_W, $clog2(N_IN), channel id width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
data_in  in  N_IN*LINK_WIDTH  per-channel flit; channel i occupies bits [i*LINK_WIDTH +: LINK_WIDTH]
valid_in  in  N_IN  per-channel flit valid
last_in  in  N_IN  per-channel last-flit-of-packet marker
ready_out  out  N_IN  per-channel accept (one-hot or zero)
data_out  out  LINK_WIDTH  link flit
valid_out  out  1  link flit valid
vc_out  out  VC_W  channel id of the link flit
last_out  out  1  last marker of the link flit
cr_upd_valid  in  1  credit return from receiver
cr_upd_vc  in  VC_W  channel of the returned credit
cr_err  out  1  sticky: credit returned to a full counter

Behaviour:
- Reset (rst=0, async): credits[i]=MAX_CREDITS, rr_ptr=0, lock=0, lock_vc=0, cr_err=0. If REG_OUT=1: valid_out=0, data_out=0, vc_out=0, last_out=0.
- Eligibility: elig[i] = valid_in[i] & (credits[i]!=0).
  - A credit returned in cycle t counts only from cycle t+1 (no same-cycle bypass).
- Arbitration when unlocked:
  - Pick the first elig[i] scanning from rr_ptr upward, modulo N_IN.
  - No eligible channel: no grant.
- Arbitration when locked:
  - Grant lock_vc only, and only if elig[lock_vc].
  - Otherwise no grant; other channels stay blocked (bubble).
- ready_out[g]=1 only for the granted channel g, combinationally. A flit transfers on valid_in[g] & ready_out[g].
- On transfer from g:
  - credits[g] decrements.
  - last_in[g]=0: lock=1, lock_vc=g.
  - last_in[g]=1: lock=0, rr_ptr=(g+1) mod N_IN.
  - rr_ptr changes only on packet completion.
  - Single-flit packets (last=1 on the first flit) never set lock.
- Credit update: if cr_upd_valid, credits[cr_upd_vc] increments.
  - Consume and return on the same channel in the same cycle: counter unchanged.
  - Return to a counter already at MAX_CREDITS with no simultaneous consume: counter saturates, cr_err set to 1 until reset.
  - cr_upd_vc >= N_IN: ignored, cr_err set.
- Output, REG_OUT=0: data/valid/vc/last_out driven combinationally from the granted flit. valid_out=1 exactly on a transfer.
- Output, REG_OUT=1: the same values are registered, so valid_out appears 1 cycle after the transfer.
  - data_out is loaded only when a transfer occurs; it holds its value otherwise.
  - valid_out=0 on cycles without a transfer.
- Link has no backpressure besides credits: valid_out is never stalled.
- Channels with valid_in=0 are never granted. A valid withdrawn mid-packet keeps the lock; the arbiter waits.
- Throughput: one flit per cycle when the selected channel has credits.
- Channel i sustains full rate only if its credit round trip is <= MAX_CREDITS cycles.

Test Plan:
- Reset, N_IN=4, MAX_CREDITS=3, REG_OUT=1: all 4 channels post single-flit packets continuously, credits returned 2 cycles after each link flit. Required: vc_out sequence 0,1,2,3,0,..., valid_out=1 every cycle from cycle 2, cr_err=0.
- Channel 1 sends a 4-flit packet while channels 0 and 2 are valid; no credit returns. Required: 3 flits of vc 1; ready_out=0000 while locked on vc 1 with zero credits. After one credit return on vc 1, the 4th flit (last_out=1) is sent, then channel 2 is granted.
- Channel 0 only, no credit returns. Required: exactly 3 flits accepted, ready_out[0]=0 from then on. One cr_upd (vc 0) -> exactly one more flit, accepted the cycle after the update.
- Channel 3 holds credits=2 and sends while cr_upd_vc=3 in the same cycle. Required: credits stay 2, no error. A cr_upd to vc 0 with credits at 3 and no send -> cr_err=1, credits[0] stays 3.
- Assert rst low mid-packet (locked on vc 2, credits[2]=1). Required: valid_out=0 immediately (async), all credits=3, lock cleared. After release, vc 0 is granted first.
- REG_OUT=0, single channel 2 with data 0xA5A5. Required: data_out=0xA5A5, vc_out=2, valid_out=1 in the same cycle as ready_out[2]=1.
